// File: rtl/pyon_pkg.sv
// Shared constants for the drawing path: screen geometry, colours, requester indices
// and the arbiter state type.
package pyon_pkg;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  localparam logic [2:0] WHITE  = 3'b111;
  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] P1_COL = 3'b100;
  localparam logic [2:0] P2_COL = 3'b001;

  localparam logic [1:0] REQ_RST = 2'd0;
  localparam logic [1:0] REQ_P1  = 2'd1;
  localparam logic [1:0] REQ_P2  = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } draw_state_t;

endpackage

// File: rtl/vga_draw_arbiter_scan.sv
// Walks the BOX_SIZE x BOX_SIZE offsets column-major (y fastest). The offsets
// presented are those of the pixel the arbiter will emit next.
module box_scan #(
  parameter int BOX_SIZE = 3
) (
  input  logic       clk,
  input  logic       start,
  input  logic       clear,
  output logic [1:0] xoff,
  output logic [1:0] yoff,
  output logic       last
);
  import pyon_pkg::*;

  localparam logic [3:0] LAST_IDX   = 4'(BOX_SIZE * BOX_SIZE - 1);
  localparam logic [3:0] FIRST_NEXT = (BOX_SIZE > 1) ? 4'd1 : 4'd0;
  localparam logic [3:0] EDGE_LEN   = 4'(BOX_SIZE);

  logic [3:0] nxt;
  logic [3:0] quo;
  logic [3:0] rem;

  // start fires on the grant edge, while pixel 0 comes out of the arbiter itself.
  always_ff @(posedge clk) begin
    if (clear)
      nxt <= 4'd0;
    else if (start)
      nxt <= FIRST_NEXT;
    else if (nxt != LAST_IDX)
      nxt <= nxt + 4'd1;
  end

  always_comb begin
    quo  = nxt / EDGE_LEN;
    rem  = nxt % EDGE_LEN;
    xoff = quo[1:0];
    yoff = rem[1:0];
    last = (nxt == LAST_IDX);
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Arbitrates restore / player one / player two for the single vga_adapter pixel
// port and paints each granted request as a BOX_SIZE square, one pixel per clock.
module vga_draw_arbiter #(
  parameter int BOX_SIZE = 3,
  parameter int SCR_W    = pyon_pkg::SCR_W,
  parameter int SCR_H    = pyon_pkg::SCR_H
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       req_rst,
  input  logic [7:0] x_rst,
  input  logic [6:0] y_rst,
  input  logic [2:0] c_rst,
  input  logic       req_p1,
  input  logic [7:0] x_p1,
  input  logic [6:0] y_p1,
  input  logic [2:0] c_p1,
  input  logic       req_p2,
  input  logic [7:0] x_p2,
  input  logic [6:0] y_p2,
  input  logic [2:0] c_p2,
  output logic [2:0] ack,
  output logic       err,
  output logic       busy,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);
  import pyon_pkg::*;

  // Handshake: a requester holds req and operands until its ack bit pulses, then
  // drops req. The ack cycle itself is never treated as a fresh request.

  draw_state_t state;
  logic        rr_p2;
  logic [1:0]  gnt;
  logic [7:0]  x_base;
  logic [6:0]  y_base;

  logic        sel_valid;
  logic [1:0]  sel;
  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [2:0]  sel_c;
  logic [2:0]  sel_onehot;
  logic        fits;
  logic        start;
  logic [1:0]  xoff;
  logic [1:0]  yoff;
  logic        last;

  always_comb begin
    sel_valid = enable && (ack == 3'b000) && (req_rst || req_p1 || req_p2);
    if (req_rst)
      sel = REQ_RST;
    else if (req_p1 && req_p2)
      sel = rr_p2 ? REQ_P2 : REQ_P1;
    else if (req_p1)
      sel = REQ_P1;
    else
      sel = REQ_P2;
    case (sel)
      REQ_RST: begin sel_x = x_rst; sel_y = y_rst; sel_c = c_rst; end
      REQ_P1:  begin sel_x = x_p1;  sel_y = y_p1;  sel_c = c_p1;  end
      default: begin sel_x = x_p2;  sel_y = y_p2;  sel_c = c_p2;  end
    endcase
    sel_onehot = 3'(3'b001 << sel);
    // Widened by one bit so a square near the right/bottom edge cannot wrap into range.
    fits = (({1'b0, sel_x} + 9'(BOX_SIZE)) <= 9'(SCR_W)) &&
           (({1'b0, sel_y} + 8'(BOX_SIZE)) <= 8'(SCR_H));
    start = (state == IDLE) && sel_valid && fits;
  end

  box_scan #(.BOX_SIZE(BOX_SIZE)) u_scan (
    .clk   (clk),
    .start (start),
    .clear (~resetn),
    .xoff  (xoff),
    .yoff  (yoff),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      rr_p2  <= 1'b0;
      gnt    <= REQ_RST;
      x_base <= '0;
      y_base <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      ack    <= 3'b000;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack  <= 3'b000;
          err  <= 1'b0;
          plot <= 1'b0;
          busy <= 1'b0;
          if (sel_valid) begin
            if (sel != REQ_RST)
              rr_p2 <= (sel == REQ_P1);
            if (fits) begin
              gnt    <= sel;
              x_base <= sel_x;
              y_base <= sel_y;
              x      <= sel_x;
              y      <= sel_y;
              colour <= sel_c;
              plot   <= 1'b1;
              busy   <= 1'b1;
              ack    <= (BOX_SIZE == 1) ? sel_onehot : 3'b000;
              state  <= DRAW;
            end else begin
              ack <= sel_onehot;
              err <= 1'b1;
            end
          end
        end
        DRAW: begin
          // A nonzero ack marks the final pixel cycle.
          if (ack != 3'b000) begin
            state <= IDLE;
            plot  <= 1'b0;
            busy  <= 1'b0;
            ack   <= 3'b000;
          end else begin
            x   <= x_base + {6'b0, xoff};
            y   <= y_base + {5'b0, yoff};
            ack <= last ? 3'(3'b001 << gnt) : 3'b000;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Shares the single vga_adapter pixel-write port between three requesters: board restore, player one and player two.
- Each granted request becomes a BOX_SIZE x BOX_SIZE square.
- The square is written one pixel per clock, with plot strobed for each pixel.
- Sits between the per-player/restore logic and vga_adapter; its x/y/colour/plot drive the adapter directly.

Parameters:
- BOX_SIZE, 3, square edge in pixels (legal 1..4)
- SCR_W, 160, screen width in pixels
- SCR_H, 120, screen height in pixels

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  reset, synchronous, active-low
- enable  in  1  game running; when low, no new grants are issued
- req_rst  in  1  restore-requester draw request
- x_rst  in  8  restore square top-left x
- y_rst  in  7  restore square top-left y
- c_rst  in  3  restore colour
- req_p1  in  1  player-one draw request
- x_p1  in  8  player-one square top-left x
- y_p1  in  7  player-one square top-left y
- c_p1  in  3  player-one colour
- req_p2  in  1  player-two draw request
- x_p2  in  8  player-two square top-left x
- y_p2  in  7  player-two square top-left y
- c_p2  in  3  player-two colour
- ack  out  3  one-hot completion pulse; bit0 restore, bit1 p1, bit2 p2
- err  out  1  pulses with ack when the request was rejected (out of range)
- busy  out  1  high while in DRAW
- x  out  8  pixel x to VGA
- y  out  7  pixel y to VGA
- colour  out  3  pixel colour to VGA
- plot  out  1  pixel write strobe

Behaviour:
- States: IDLE, DRAW. All outputs are registered.
- Reset (resetn=0 at a clk edge, including mid-DRAW): state=IDLE, pixel counter=0, rr pointer=p1.
- Reset values: x=0, y=0, colour=0, plot=0, ack=0, err=0, busy=0. An in-progress square is abandoned with no ack.
- IDLE arbitration (evaluated only when enable=1):
  - req_rst has fixed highest priority.
  - Between p1 and p2: round-robin. The rr pointer names the preferred player and flips to the other player after each player grant.
  - Restore grants do not move the pointer.
- Range check at grant: reject if x_i+BOX_SIZE > SCR_W or y_i+BOX_SIZE > SCR_H, computed at 9-bit/8-bit width with no wrap.
  - Rejected: next cycle ack[i]=1, err=1, plot=0; state stays IDLE.
- Accepted request:
  - Latch x_i, y_i, c_i and the grant index.
  - Go to DRAW with counter k=0.
- DRAW, cycle k (k=0..BOX_SIZE²-1):
  - x = xlat + k/BOX_SIZE, y = ylat + k%BOX_SIZE, colour = clat, plot=1, busy=1.
  - Scan is column-major, y fastest: (0,0),(0,1),(0,2),(1,0)…(2,2).
- Completion: ack[grant]=1 during the cycle of the last pixel (k=BOX_SIZE²-1); next state IDLE with plot=0.
- Latency: req sampled in IDLE at edge t.
  - First pixel visible in cycle t+1; last pixel and ack in cycle t+9 (BOX_SIZE=3).
  - IDLE in cycle t+10; the next grant has its first pixel in t+11. There is exactly one idle cycle between squares.
- Requester rules:
  - Hold req and its operands stable until ack.
  - Drop req in the cycle after ack.
  - req still high in the IDLE cycle after ack is taken as a new request.
  - Operands changing during DRAW have no effect (values are latched).
- Enable:
  - enable=0 blocks new grants only.
  - A DRAW in progress always completes and acks.
- Simultaneous requests:
  - rst+p1+p2 → rst is served first.
  - Then the player at the rr pointer, then the other player.
  - No requester is starved while its req is held.
- Outside DRAW, x/y/colour hold their last values; only plot qualifies a write.

Decomposition:
- Shared package pyon_pkg holds:
  - SCR_W and SCR_H.
  - Colour constants: WHITE=3'b111, BLACK=3'b000, P1_COL, P2_COL.
  - Requester indices: REQ_RST=0, REQ_P1=1, REQ_P2=2.
- Sub-module box_scan:
  - Inputs: start, clear (sync).
  - Outputs: xoff[1:0], yoff[1:0], last.
  - Counts through BOX_SIZE² offsets.
  - Replaces the unclocked offset-table approach.

Test Plan:
- Single p1 request at (37,3), colour 3'b110, enable=1:
  - 9 plot cycles: (37,3),(37,4),(37,5),(38,3)…(39,5).
  - ack=3'b010 on the 9th; busy high exactly 9 cycles.
- req_rst, req_p1 and req_p2 asserted together at reset rr:
  - Grant order rst, p1, p2.
  - Acks in cycles 9, 19, 29 after the first sample.
- p1 and p2 both held continuously for 4 squares:
  - Grants alternate p1, p2, p1, p2, with one idle cycle between squares.
- p2 request at (158,10):
  - Next cycle ack=3'b100 with err=1; no plot pulses.
  - (157,117) is accepted and drawn.
- resetn=0 at pixel 4 of a p1 square:
  - Next cycle plot=0, busy=0, ack=0, x=y=0.
  - A p1 request re-asserted afterwards restarts at pixel (x_p1, y_p1).
- enable dropped at pixel 2 of a p2 square, with req_p1 pending:
  - The square completes with ack=3'b100.
  - p1 is not granted until enable returns to 1, then drawn 1 cycle later.
